// File: rtl/avr_io_initiator.sv
// avr_io_initiator
//   Bus master for the AVR 6-bit IO space. It takes single commands from a
//   valid/ready port and turns each one into a correctly timed IO write or
//   IO read cycle. Read data comes back on a response port. The debug/boot
//   loader path uses it, and bench stimulus uses it to reach peripherals
//   without the CPU core.
//
//   Optional feature macro: AVR_IO_BITOP_EN
//     defined   : ops 10/11 perform read-modify-write set/clear of bit wdata[2:0]
//     undefined : ops 10/11 complete at once with rsp_err=1 and no bus activity
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op               00 read, 01 write, 10 set bit, 11 clear bit
//   cmd_addr, cmd_wdata  target address, write data / bit index in [2:0]
//   rsp_valid            one-cycle completion pulse
//   rsp_data, rsp_err    read/written value, unsupported-op flag
//   io_addr, io_data     IO bus address, bidirectional data (driven only on write)
//   io_write, io_read    IO strobes, never high together
//   busy                 inverse of cmd_ready
module avr_io_initiator #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] io_addr,
  inout  wire  [DATA_W-1:0] io_data,
  output logic              io_write,
  output logic              io_read,
  output logic              busy
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  // DONE is not a separate state: completion is just a registered rsp_valid
  // pulse raised while returning to IDLE. This lets a new command be
  // accepted in the same cycle as the pulse.
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_A,
    RD_B,
    MOD_WR
  } state_t;

  state_t            state, state_next;
  logic              accept;
  logic [DATA_W-1:0] wdata_lat;
  logic [DATA_W-1:0] dout, dout_next;
  logic [ADDR_W-1:0] io_addr_next;
  logic              io_write_next, io_read_next;
  logic              rsp_valid_next, rsp_err_next;
  logic [DATA_W-1:0] rsp_data_next;

`ifdef AVR_IO_BITOP_EN
  logic [1:0]        op_lat;
  logic [DATA_W-1:0] sample, sample_next;
  logic [DATA_W-1:0] bit_mask;

  always_comb begin
    bit_mask = '0;
    bit_mask[wdata_lat[2:0]] = 1'b1;
  end
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  // The data bus is released whenever the write strobe is low. The read
  // strobe is only raised in read states, where io_write is 0, so this
  // drive can never collide with a responder.
  assign io_data = io_write ? dout : {DATA_W{1'bz}};

  always_comb begin
    state_next     = state;
    io_addr_next   = io_addr;
    io_write_next  = 1'b0;
    io_read_next   = 1'b0;
    dout_next      = dout;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;
`ifdef AVR_IO_BITOP_EN
    sample_next    = sample;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          io_addr_next = cmd_addr;
          if (cmd_op == OP_WR) begin
            state_next    = WR;
            io_write_next = 1'b1;
            dout_next     = cmd_wdata;
          end else if (cmd_op == OP_RD) begin
            state_next   = RD_A;
            io_read_next = 1'b1;
          end else begin
`ifdef AVR_IO_BITOP_EN
            // Bit ops begin with the same two-cycle read as a plain read.
            state_next   = RD_A;
            io_read_next = 1'b1;
`else
            // Unsupported: respond next cycle, stay in IDLE, touch no strobes.
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_data_next  = '0;
`endif
          end
        end
      end
      WR: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_data_next  = wdata_lat;
        rsp_err_next   = 1'b0;
      end
      RD_A: begin
        // The responder registers its data during this cycle. Keep the
        // strobe up so that it drives in RD_B.
        state_next   = RD_B;
        io_read_next = 1'b1;
      end
      RD_B: begin
`ifdef AVR_IO_BITOP_EN
        if (op_lat != OP_RD) begin
          state_next    = MOD_WR;
          io_write_next = 1'b1;
          sample_next   = io_data;
          dout_next     = op_lat[0] ? (io_data & ~bit_mask) : (io_data | bit_mask);
        end else begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_data_next  = io_data;
          rsp_err_next   = 1'b0;
        end
`else
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_data_next  = io_data;
        rsp_err_next   = 1'b0;
`endif
      end
`ifdef AVR_IO_BITOP_EN
      MOD_WR: begin
        // Report the value seen before modification.
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_data_next  = sample;
        rsp_err_next   = 1'b0;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      io_addr   <= '0;
      io_write  <= 1'b0;
      io_read   <= 1'b0;
      dout      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      wdata_lat <= '0;
`ifdef AVR_IO_BITOP_EN
      op_lat    <= OP_RD;
      sample    <= '0;
`endif
    end else begin
      state     <= state_next;
      io_addr   <= io_addr_next;
      io_write  <= io_write_next;
      io_read   <= io_read_next;
      dout      <= dout_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
`ifdef AVR_IO_BITOP_EN
      sample    <= sample_next;
`endif
      if (accept) begin
        wdata_lat <= cmd_wdata;
`ifdef AVR_IO_BITOP_EN
        op_lat    <= cmd_op;
`endif
      end
    end
  end

endmodule

// File: tb/tb_avr_io_initiator.sv
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_avr_io_initiator;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] io_addr;
  wire  [DW-1:0] io_data;
  logic          io_write;
  logic          io_read;
  logic          busy;

  avr_io_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .io_addr(io_addr), .io_data(io_data), .io_write(io_write),
    .io_read(io_read), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [0:63];
  logic [DW-1:0] rd_q;
  logic          rd_d;
  always @(posedge clk) begin
    if (rst) rd_d <= 1'b0;
    else     rd_d <= io_read;
    if (io_read)  rd_q <= regs[io_addr];
    if (io_write) regs[io_addr] <= io_data;
  end
  assign io_data = (io_read && rd_d) ? rd_q : {DW{1'bz}};

  typedef struct packed { logic [DW-1:0] data; logic err; } rsp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } bus_t;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  logic [DW-1:0] model [0:63];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  rsp_t er;
  bus_t eb;
  always @(negedge clk) begin
    if (io_write || io_read) begin
      total++;
      if ((io_write && io_read) === 1'b0) passed++;
      else $error("FAIL strobe_excl: io_write and io_read both high");
    end
    if (rsp_valid) begin
      `CHK("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        er = rsp_q.pop_front();
        total++;
        if (rsp_data === er.data) passed++;
        else $error("FAIL rsp_data: observed 0x%0h expected 0x%0h", rsp_data, er.data);
        total++;
        if (rsp_err === er.err) passed++;
        else $error("FAIL rsp_err: observed %0b expected %0b", rsp_err, er.err);
      end
    end
    if (io_write) begin
      `CHK("bus_wr_expected", bus_q.size() != 0, 1);
      if (bus_q.size() != 0) begin
        eb = bus_q.pop_front();
        total++;
        if (io_addr === eb.addr) passed++;
        else $error("FAIL bus_wr_addr: observed 0x%0h expected 0x%0h", io_addr, eb.addr);
        total++;
        if (io_data === eb.data) passed++;
        else $error("FAIL bus_wr_data: observed 0x%0h expected 0x%0h", io_data, eb.data);
      end
    end
  end

  task automatic expect_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] s, m, one;
    case (op)
      2'b00: rsp_q.push_back('{data: model[a], err: 1'b0});
      2'b01: begin
        bus_q.push_back('{addr: a, data: wd});
        model[a] = wd;
        rsp_q.push_back('{data: wd, err: 1'b0});
      end
      default: begin
`ifdef AVR_IO_BITOP_EN
        s   = model[a];
        one = 8'h01;
        m   = (op == 2'b10) ? (s | (one << wd[2:0])) : (s & ~(one << wd[2:0]));
        bus_q.push_back('{addr: a, data: m});
        model[a] = m;
        rsp_q.push_back('{data: s, err: 1'b0});
`else
        s = '0; m = '0; one = '0;
        rsp_q.push_back('{data: s | m | one, err: 1'b1});
`endif
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    expect_cmd(op, a, wd);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    `CHK("accept_in_time", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    `CHK("rst_ready", cmd_ready, 1);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_io_write", io_write, 0);
    `CHK("rst_io_read", io_read, 0);
    `CHK("rst_io_addr", io_addr, 0);
    `CHK("rst_rsp_valid", rsp_valid, 0);
    `CHK("rst_rsp_data", rsp_data, 0);
    `CHK("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;

    issue(2'b01, 6'h12, 8'h2A, 1'b0);
    @(negedge clk);
    `CHK("wr_n1_io_write", io_write, 1);
    `CHK("wr_n1_io_addr", io_addr, 6'h12);
    `CHK("wr_n1_io_data", io_data, 8'h2A);
    `CHK("wr_n1_rsp_valid", rsp_valid, 0);
    `CHK("wr_n1_busy", busy, 1);
    @(negedge clk);
    `CHK("wr_n2_io_write", io_write, 0);
    `CHK("wr_n2_rsp_valid", rsp_valid, 1);
    `CHK("wr_n2_ready", cmd_ready, 1);
    `CHK("wr_n2_io_addr_hold", io_addr, 6'h12);
    `CHK("tcnt_value", regs[6'h12], 8'h2A);

    issue(2'b01, 6'h13, 8'h05, 1'b0);
    issue(2'b00, 6'h13, 8'h00, 1'b0);
    @(negedge clk);
    `CHK("rd_n1_io_read", io_read, 1);
    `CHK("rd_n1_io_write", io_write, 0);
    `CHK("rd_n1_io_addr", io_addr, 6'h13);
    @(negedge clk);
    `CHK("rd_n2_io_read", io_read, 1);
    `CHK("rd_n2_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    `CHK("rd_n3_io_read", io_read, 0);
    `CHK("rd_n3_rsp_valid", rsp_valid, 1);
    `CHK("rd_n3_rsp_data", rsp_data, 8'h05);

    issue(2'b01, 6'h14, 8'h77, 1'b1);
    cmd_op = 2'b00; cmd_addr = 6'h14; cmd_wdata = 8'h00;
    expect_cmd(2'b00, 6'h14, 8'h00);
    @(negedge clk);
    `CHK("b2b_n1_ready", cmd_ready, 0);
    @(negedge clk);
    `CHK("b2b_n2_rsp_valid", rsp_valid, 1);
    `CHK("b2b_n2_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    `CHK("b2b_no_gap_io_read", io_read, 1);
    `CHK("b2b_io_addr", io_addr, 6'h14);
    @(negedge clk);
    @(negedge clk);
    `CHK("b2b_rd_rsp_valid", rsp_valid, 1);

    issue(2'b01, 6'h15, 8'h3C, 1'b0);
    cmd_addr = 6'h2F; cmd_wdata = 8'hFF;
    @(negedge clk);
    `CHK("latched_io_addr", io_addr, 6'h15);
    `CHK("latched_io_data", io_data, 8'h3C);
    @(negedge clk);
    `CHK("latched_rsp_data", rsp_data, 8'h3C);

    issue(2'b00, 6'h12, 8'h00, 1'b0);
    @(posedge clk); #1;
    void'(rsp_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    `CHK("abort_io_read", io_read, 0);
    `CHK("abort_io_write", io_write, 0);
    `CHK("abort_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    `CHK("abort_ready", cmd_ready, 1);
    `CHK("abort_no_rsp", rsp_valid, 0);

`ifdef AVR_IO_BITOP_EN
    issue(2'b01, 6'h20, 8'h05, 1'b0);
    issue(2'b10, 6'h20, 8'h03, 1'b0);
    @(negedge clk);
    `CHK("set_n1_io_read", io_read, 1);
    @(negedge clk);
    @(negedge clk);
    `CHK("set_n3_io_write", io_write, 1);
    `CHK("set_n3_io_data", io_data, 8'h0D);
    `CHK("set_n3_io_read", io_read, 0);
    @(negedge clk);
    `CHK("set_n4_rsp_valid", rsp_valid, 1);
    `CHK("set_n4_rsp_data", rsp_data, 8'h05);
    issue(2'b11, 6'h20, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    `CHK("clr_reg_value", regs[6'h20], 8'h0C);
`else
    issue(2'b10, 6'h20, 8'h03, 1'b0);
    @(negedge clk);
    `CHK("bitop_rsp_valid", rsp_valid, 1);
    `CHK("bitop_rsp_err", rsp_err, 1);
    `CHK("bitop_rsp_data", rsp_data, 0);
    `CHK("bitop_no_write", io_write, 0);
    `CHK("bitop_no_read", io_read, 0);
    issue(2'b11, 6'h21, 8'h00, 1'b0);
    @(negedge clk);
    `CHK("bitclr_rsp_err", rsp_err, 1);
`endif

    for (int i = 0; i < 8; i++) issue(2'b01, 6'(6'h30 + i), 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom_range(0, 1)), 6'(6'h30 + $urandom_range(0, 7)),
            8'($urandom_range(0, 255)), 1'b0);
    end

    repeat (6) @(negedge clk);
    `CHK("rsp_queue_drained", rsp_q.size(), 0);
    `CHK("bus_queue_drained", bus_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avr_io_initiator.md
Name: avr_io_initiator

Overview:
Bus master for the AVR 6-bit IO space; the initiator end of the io_addr/io_data/io_write/io_read protocol that peripherals such as the timer respond to.
Converts single commands from a valid/ready interface into correctly timed IO write and IO read cycles, and returns read data on a response port.
Used by the debug/boot loader path and by bench stimulus to access peripherals without the CPU core.

Parameters:
ADDR_W, 6, IO address width; drives io_addr.
DATA_W, 8, IO data width.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high when idle and able to accept a command
cmd_op  input  2  00 read, 01 write, 10 set bit, 11 clear bit
cmd_addr  input  ADDR_W  target IO address
cmd_wdata  input  DATA_W  write data; bit ops use [2:0] as bit index
rsp_valid  output  1  one-cycle pulse: command complete
rsp_data  output  DATA_W  read value (read/bit op) or written value (write)
rsp_err  output  1  valid with rsp_valid; 1 = unsupported op
io_addr  output  ADDR_W  IO bus address
io_data  inout  DATA_W  IO bus data; driven only while io_write=1, else Z
io_write  output  1  IO write strobe
io_read  output  1  IO read strobe
busy  output  1  inverse of cmd_ready

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset values: state IDLE, io_write=0, io_read=0, io_data Z, io_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- cmd_ready = (state==IDLE). Accept on posedge with cmd_valid && cmd_ready; latch op, addr, wdata. Inputs are ignored when not ready or during rst.
- States: IDLE, WR, RD_A, RD_B, MOD_WR (feature only), DONE (folded into IDLE via registered rsp_valid).
- Write (accepted end of cycle N): cycle N+1 WR: io_addr=addr, io_write=1, io_data=wdata. Cycle N+2: IDLE, rsp_valid=1, rsp_data=wdata, rsp_err=0.
- Read: cycle N+1 RD_A, io_read=1, io_addr=addr (responder registers its data). Cycle N+2 RD_B, io_read=1, same addr; io_data sampled at end of N+2. Cycle N+3: IDLE, rsp_valid=1, rsp_data=sample.
- io_write and io_read are never high together. io_data is never driven while io_read=1.
- io_addr holds its last value in IDLE. Strobes are 0 in IDLE.
- Back-to-back: a command may be accepted in the same cycle rsp_valid pulses. Throughput is 2 cycles per write and 3 cycles per read.
- All bus outputs and response outputs are registered.
- rst mid-operation: on the next edge, state IDLE, strobes 0, io_data released, no rsp_valid for the aborted command.

Optional Feature:
AVR_IO_BITOP_EN
- Defined:
  - cmd_op 10/11 run RD_A, RD_B, then MOD_WR.
  - MOD_WR: io_write=1, io_data = sample with bit wdata[2:0] set (10) or cleared (11).
  - Next cycle: rsp_valid=1, rsp_data = original sample, rsp_err=0. Total latency 4 cycles.
- Not defined:
  - cmd_op 10/11 are accepted and cause no bus activity.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0.

Test Plan:
- Write 0x2A to 0x12 with timer responder at IO_ADDR=0x12 -> io_write high only in N+1 with io_data=0x2A; TCNT=0x2A; rsp_valid at N+2 with rsp_data=0x2A.
- Write 0x05 to 0x13, then read 0x13 -> io_read high exactly 2 cycles; initiator never drives io_data; rsp_valid at N+3 with rsp_data=0x05.
- cmd_valid held high with write then read queued -> read accepted in the same cycle as the write's rsp_valid; no idle gap; strobes never overlap.
- rst asserted during RD_B -> next cycle io_read=0, io_data Z, no rsp_valid; cmd_ready=1 after rst drops.
- With AVR_IO_BITOP_EN: register holds 0x05; set bit 3 -> bus writes 0x0D, rsp_data=0x05; then clear bit 0 -> bus writes 0x0C. Without the macro: same op gives rsp_err=1 one cycle after accept, no strobes.
- cmd_addr/cmd_wdata changed while busy -> bus uses the latched values only; a single rsp_valid per accepted command.
